id_ex_bundle_reg: RTL and testbench
===================================

Name: id_ex_bundle_reg

Overview:
- Parametrised ID→EX pipeline register for the multi-issue MIPS core; generalises the fixed dual-issue ID/EX register to LANES slots.
- Adds a per-lane valid mask, a valid/ready handshake with a 2-entry skid buffer (registered in_ready), and a flush.
- Adds a saturating stall counter.
- Sits between the decode stage (producer) and the issue/execute stage (consumer).

Parameters:
- LANES, 2, instructions per bundle (1..8)
- INSTR_W, 32, width of one decoded instruction word
- PC_W, 32, width of bundle PC
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  discard all held bundles (branch mispredict/exception)
- in_valid  in  1  decode presents a bundle
- in_ready  out  1  register can accept a bundle
- in_pc  in  PC_W  bundle PC
- in_instr  in  LANES*INSTR_W  lane i at bits [i*INSTR_W +: INSTR_W]
- in_lane_vld  in  LANES  per-lane valid mask
- out_valid  out  1  bundle available to EX
- out_ready  in  1  EX accepts bundle
- out_pc  out  PC_W  held bundle PC
- out_instr  out  LANES*INSTR_W  held instructions
- out_lane_vld  out  LANES  held lane mask
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (reset=0, takes effect without a clock edge):
  - main and skid slots empty
  - out_valid=0, out_pc=0, out_instr=0 (all-zero = NOP), out_lane_vld=0
  - stall_cnt=0
  - in_ready=1
- Storage: main slot drives outputs; skid slot holds one overflow bundle. in_ready = !skid_valid, a direct flop output with no combinational path from out_ready.
- Handshakes:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - Transfers occur at the rising edge.
- Latency: a bundle pushed into an empty register appears on the outputs the next cycle. Sustained throughput is 1 bundle/cycle when out_ready=1.
- Slot transitions per edge (flush=0):
  - main empty, push → main <= input.
  - main full, pop, no push → main empties; outputs return to zero/NOP.
  - main full, pop & push, skid empty → main <= input.
  - main full, no pop, push → skid <= input; in_ready drops next cycle.
  - skid full (so no push possible), pop → main <= skid, skid empties, in_ready=1 next cycle.
  - No pop, no push → hold all.
- Empty main forces out_instr=0, out_pc=0, out_lane_vld=0 and out_valid=0. EX must never see stale data.
- A bundle with in_lane_vld=0 is accepted and forwarded as a normal bundle with out_valid=1. It is not squashed here.
- Lane data is carried verbatim. in_lane_vld is not applied to in_instr: an invalid lane's word is stored as given.
- flush=1 at an edge:
  - both slots are emptied and all outputs are zeroed next cycle; in_ready=1.
  - A simultaneous push is dropped. The producer sees a completed handshake and must treat it as flushed.
  - A simultaneous pop still counts as consumed by EX.
  - flush has priority over everything except reset.
- stall_cnt:
  - increments by 1 on each edge where out_valid=1 and out_ready=0
  - saturates at all-ones
  - not cleared by flush; cleared only by reset
- out_ready is ignored when out_valid=0.
- Reset asserted mid-transfer: all state is lost immediately. After deassertion, the first edge behaves as from an empty register.

Decomposition:
- Shared package mips_pipe_pkg:
  - NOP_WORD (32'h0000_0000)
  - default LANES and INSTR_W
  - a bundle typedef (pc, instr array, lane_vld) if the flow supports it
- One sub-module: bundle_slot. It holds one bundle plus a valid flag, with load/clear controls and async active-low reset. Instantiate it twice (main, skid).

Test Plan:
- Reset: reset=0 with random inputs → out_valid=0, out_instr=0, stall_cnt=0, in_ready=1. Release, push pc=0x100, instr={0x8C010004,0x00221820} → appears next cycle, out_lane_vld=2'b11.
- Streaming: 8 back-to-back bundles, out_ready=1 → 8 outputs in order, one per cycle, in_ready stays 1, stall_cnt=0.
- Backpressure: out_ready=0 with pushes at pc=0x200, 0x204, 0x208 → first two held (main, skid), in_ready=0 after the second, third not accepted. out_ready=1 → 0x200, 0x204, 0x208 emerge in order; stall_cnt = number of stalled cycles.
- Flush with full skid plus simultaneous push → next cycle out_valid=0, out_instr=0, in_ready=1, pushed bundle absent; stall_cnt unchanged.
- Partial bundle: in_lane_vld=2'b01, lane1 word 0xDEADBEEF → out_valid=1, out_lane_vld=2'b01, lane1 word carried verbatim.
- Saturation (CNT_W=4): out_ready=0 for 20 cycles with a valid bundle → stall_cnt=15 and holds.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants and bundle layout for the multi-issue MIPS pipeline registers.
// Default geometry matches the dual-issue core.
package mips_pipe_pkg;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          LANES_DEF   = 2;
    localparam int          INSTR_W_DEF = 32;
    localparam int          PC_W_DEF    = 32;
    localparam int          CNT_W_DEF   = 16;

    // Packed bundle for the default geometry; field order matches the slot storage word.
    typedef struct packed {
        logic [PC_W_DEF-1:0]                     pc;
        logic [LANES_DEF-1:0][INSTR_W_DEF-1:0]   instr;
        logic [LANES_DEF-1:0]                    lane_vld;
    } bundle_t;

endpackage

// File: rtl/id_ex_bundle_reg_bundle_slot.sv
// One bundle storage slot with a valid flag. Clearing zeroes the data so an
// empty slot always reads as an all-NOP bundle.
module bundle_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // Slot storage: clear wins over load, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q     <= {W{1'b0}};
            valid <= 1'b0;
        end else if (clear) begin
            q     <= {W{1'b0}};
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_bundle_reg.sv
// ID->EX pipeline register for LANES-wide bundles: main slot drives EX, a skid
// slot absorbs one bundle so in_ready can be a flop with no path from out_ready.
module id_ex_bundle_reg
    import mips_pipe_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [LANES*INSTR_W-1:0] in_instr,
    input  logic [LANES-1:0]         in_lane_vld,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [LANES*INSTR_W-1:0] out_instr,
    output logic [LANES-1:0]         out_lane_vld,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int DW = PC_W + LANES*INSTR_W + LANES;

    logic          in_ready_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic          main_valid_r, skid_valid_r;
    logic [DW-1:0] main_data_r, skid_data_r;
    logic [DW-1:0] in_data_s, main_d_s;
    logic          push_s, pop_s;
    logic          main_load_s, main_clear_s, skid_load_s, skid_clear_s;
    logic          skid_valid_next_s;

    assign in_data_s = {in_pc, in_instr, in_lane_vld};
    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = main_valid_r & out_ready;

    // Slot transition control; flush empties both slots and drops any push.
    always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        main_d_s     = in_data_s;
        if (flush) begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else if (!main_valid_r) begin
            main_load_s = push_s;
        end else if (pop_s) begin
            if (skid_valid_r) begin
                main_load_s  = 1'b1;
                main_d_s     = skid_data_r;
                skid_clear_s = 1'b1;
            end else if (push_s) begin
                main_load_s = 1'b1;
            end else begin
                main_clear_s = 1'b1;
            end
        end else begin
            skid_load_s = push_s;
        end
    end

    // Next skid occupancy, used to register in_ready one cycle ahead.
    always_comb begin
        if (skid_clear_s) begin
            skid_valid_next_s = 1'b0;
        end else if (skid_load_s) begin
            skid_valid_next_s = 1'b1;
        end else begin
            skid_valid_next_s = skid_valid_r;
        end
    end

    bundle_slot #(.W(DW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load_s),
        .clear (main_clear_s),
        .d     (main_d_s),
        .q     (main_data_r),
        .valid (main_valid_r)
    );

    bundle_slot #(.W(DW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .clear (skid_clear_s),
        .d     (in_data_s),
        .q     (skid_data_r),
        .valid (skid_valid_r)
    );

    // in_ready flop: mirrors an empty skid slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= ~skid_valid_next_s;
        end
    end

    // Saturating stall counter; flush leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (main_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end
    end

    assign in_ready                          = in_ready_r;
    assign out_valid                         = main_valid_r;
    assign {out_pc, out_instr, out_lane_vld} = main_data_r;
    assign stall_cnt                         = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_bundle_reg.sv
// Directed self-checking bench for id_ex_bundle_reg (LANES=2, CNT_W=4).
module tb_id_ex_bundle_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [63:0] in_instr;
    logic [1:0]  in_lane_vld;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [63:0] out_instr;
    logic [1:0]  out_lane_vld;
    logic [3:0]  stall_cnt;

    int pass_cnt;
    int total_cnt;

    id_ex_bundle_reg #(.LANES(2), .INSTR_W(32), .PC_W(32), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_lane_vld  (in_lane_vld),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_lane_vld (out_lane_vld),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = 32'h0;
        in_instr    = 64'h0;
        in_lane_vld = 2'b00;
        out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        flush       = 1'(($urandom & 32'h1));
        in_valid    = 1'b1;
        in_pc       = $urandom;
        in_instr    = {$urandom, $urandom};
        in_lane_vld = 2'b10;
        out_ready   = 1'b0;
        step();
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_instr, out_lane_vld} !== 99'h0) begin
            $display("FAIL reset_outputs: got valid=%0b pc=%h instr=%h lv=%b, want all zero", out_valid, out_pc, out_instr, out_lane_vld);
        end else pass_cnt++;
        total_cnt++;
        if ({in_ready, stall_cnt} !== 5'b1_0000) begin
            $display("FAIL reset_ready_cnt: got in_ready=%0b stall=%0d, want 1/0", in_ready, stall_cnt);
        end else pass_cnt++;
        // first push after release
        idle_inputs();
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_pc       = 32'h100;
        in_instr    = {32'h8C010004, 32'h00221820};
        in_lane_vld = 2'b11;
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_instr, out_lane_vld} !== {1'b1, 32'h100, 32'h8C010004, 32'h00221820, 2'b11}) begin
            $display("FAIL first_push: got valid=%0b pc=%h instr=%h lv=%b, want 1 100 8c01000400221820 11", out_valid, out_pc, out_instr, out_lane_vld);
        end else pass_cnt++;
        // asynchronous reset while loaded
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_pc, out_instr, in_ready} !== {1'b0, 96'h0, 1'b1}) begin
            $display("FAIL async_reset: got valid=%0b pc=%h instr=%h in_ready=%0b, want 0 0 0 1", out_valid, out_pc, out_instr, in_ready);
        end else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        logic [63:0] exp_instr;
        int          errs;
        do_reset();
        out_ready = 1'b1;
        errs      = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            in_pc       = 32'h1000 + 32'(i * 4);
            in_instr    = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
            in_lane_vld = 2'b11;
            step();
            exp_pc    = 32'h1000 + 32'(i * 4);
            exp_instr = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
            total_cnt++;
            if ({out_valid, out_pc, out_instr, in_ready} !== {1'b1, exp_pc, exp_instr, 1'b1}) begin
                $display("FAIL stream_%0d: got valid=%0b pc=%h instr=%h in_ready=%0b, want 1 %h %h 1", i, out_valid, out_pc, out_instr, in_ready, exp_pc, exp_instr);
                errs++;
            end else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        total_cnt++;
        if ({out_valid, out_pc, stall_cnt} !== {1'b0, 32'h0, 4'd0}) begin
            $display("FAIL stream_drain: got valid=%0b pc=%h stall=%0d, want 0 0 0", out_valid, out_pc, stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_lane_vld = 2'b11;
        in_pc       = 32'h200;
        in_instr    = 64'h200;
        step();
        total_cnt++;
        if ({out_valid, out_pc, in_ready} !== {1'b1, 32'h200, 1'b1}) begin
            $display("FAIL bp_first: got valid=%0b pc=%h in_ready=%0b, want 1 200 1", out_valid, out_pc, in_ready);
        end else pass_cnt++;
        in_pc    = 32'h204;
        in_instr = 64'h204;
        step();
        total_cnt++;
        if ({out_pc, in_ready, stall_cnt} !== {32'h200, 1'b0, 4'd1}) begin
            $display("FAIL bp_skid_full: got pc=%h in_ready=%0b stall=%0d, want 200 0 1", out_pc, in_ready, stall_cnt);
        end else pass_cnt++;
        in_pc    = 32'h208;
        in_instr = 64'h208;
        step();
        total_cnt++;
        if ({out_pc, in_ready, stall_cnt} !== {32'h200, 1'b0, 4'd2}) begin
            $display("FAIL bp_refused: got pc=%h in_ready=%0b stall=%0d, want 200 0 2", out_pc, in_ready, stall_cnt);
        end else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_instr, in_ready} !== {1'b1, 32'h204, 64'h204, 1'b1}) begin
            $display("FAIL bp_drain_204: got valid=%0b pc=%h instr=%h in_ready=%0b, want 1 204 204 1", out_valid, out_pc, out_instr, in_ready);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h208, 64'h208}) begin
            $display("FAIL bp_drain_208: got valid=%0b pc=%h instr=%h, want 1 208 208", out_valid, out_pc, out_instr);
        end else pass_cnt++;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if ({out_valid, out_pc, stall_cnt} !== {1'b0, 32'h0, 4'd2}) begin
            $display("FAIL bp_empty: got valid=%0b pc=%h stall=%0d, want 0 0 2", out_valid, out_pc, stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_lane_vld = 2'b11;
        in_pc       = 32'h300;
        in_instr    = 64'h1111_2222_3333_4444;
        step();
        in_pc = 32'h304;
        step();
        // skid full, producer still presenting, EX pops on the flush edge
        in_pc     = 32'h308;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_instr, out_lane_vld, in_ready, stall_cnt} !== {1'b0, 96'h0, 2'b00, 1'b1, 4'd1}) begin
            $display("FAIL flush_skid: got valid=%0b pc=%h instr=%h lv=%b in_ready=%0b stall=%0d, want 0 0 0 00 1 1", out_valid, out_pc, out_instr, out_lane_vld, in_ready, stall_cnt);
        end else pass_cnt++;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if ({out_valid, out_pc} !== {1'b0, 32'h0}) begin
            $display("FAIL flush_absent: got valid=%0b pc=%h, want 0 0", out_valid, out_pc);
        end else pass_cnt++;
        // accepted push coinciding with flush is dropped
        in_valid = 1'b1;
        in_pc    = 32'h310;
        step();
        in_pc = 32'h314;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if ({out_valid, out_pc, in_ready, stall_cnt} !== {1'b0, 32'h0, 1'b1, 4'd1}) begin
            $display("FAIL flush_push_drop: got valid=%0b pc=%h in_ready=%0b stall=%0d, want 0 0 1 1", out_valid, out_pc, in_ready, stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_partial();
        do_reset();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_pc       = 32'h400;
        in_instr    = {32'hDEADBEEF, 32'h1234_5678};
        in_lane_vld = 2'b01;
        step();
        total_cnt++;
        if ({out_valid, out_lane_vld, out_instr} !== {1'b1, 2'b01, 32'hDEADBEEF, 32'h1234_5678}) begin
            $display("FAIL partial_lane: got valid=%0b lv=%b instr=%h, want 1 01 deadbeef12345678", out_valid, out_lane_vld, out_instr);
        end else pass_cnt++;
        out_ready   = 1'b1;
        in_pc       = 32'h404;
        in_instr    = {32'hCAFE_F00D, 32'h0BAD_0BAD};
        in_lane_vld = 2'b00;
        step();
        total_cnt++;
        if ({out_valid, out_pc, out_lane_vld, out_instr} !== {1'b1, 32'h404, 2'b00, 32'hCAFE_F00D, 32'h0BAD_0BAD}) begin
            $display("FAIL empty_mask: got valid=%0b pc=%h lv=%b instr=%h, want 1 404 00 cafef00d0bad0bad", out_valid, out_pc, out_lane_vld, out_instr);
        end else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_pc       = 32'h500;
        in_lane_vld = 2'b11;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        total_cnt++;
        if (stall_cnt !== 4'd14) begin
            $display("FAIL sat_pre: got stall=%0d, want 14", stall_cnt);
        end else pass_cnt++;
        for (int i = 0; i < 6; i++) step();
        total_cnt++;
        if ({out_valid, out_pc, stall_cnt} !== {1'b1, 32'h500, 4'd15}) begin
            $display("FAIL sat_hold: got valid=%0b pc=%h stall=%0d, want 1 500 15", out_valid, out_pc, stall_cnt);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_partial();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
